// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: frame-level controller for serial pattern detection.
// Accepts parallel words over valid/ready, serialises them MSB-first, runs a
// programmable pattern matcher (pattern, length, overlap mode) on the stream,
// counts matches per frame and reports busy/done.
module seq_det_ctrl #(
  parameter int W  = 8,
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [PW-1:0]             cfg_pattern,
  input  logic [$clog2(PW+1)-1:0]   cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      start,
  input  logic [7:0]                frame_words,
  input  logic                      in_valid,
  input  logic [W-1:0]              in_data,
  output logic                      in_ready,
  output logic                      bit_out,
  output logic                      bit_valid,
  output logic                      match,
  output logic [CW-1:0]             match_count,
  output logic                      busy,
  output logic                      done
);

  localparam int LW = $clog2(PW + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  // Power-on configuration: detect ...1010, length 4, overlapping matches
  localparam logic [PW-1:0] PAT_RST = PW'(4'b1010);
  localparam logic [LW-1:0] LEN_RST = LW'(4);
  localparam logic [LW-1:0] LEN_MAX = LW'(PW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;

  logic [PW-1:0]   pat_q, pat_d;
  logic [LW-1:0]   len_q, len_d;
  logic            ovl_q, ovl_d;

  logic [7:0]      words_left_q, words_left_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;

  // History holds the PW-1 bits preceding the current one; bit 0 is the newest
  logic [PW-2:0]   hist_q, hist_d;
  logic [LW-1:0]   seen_q, seen_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PW-1:0]   cand;
  logic [PW-1:0]   len_mask;
  logic [LW:0]     seen_inc;
  logic            last_bit;

  // State register; reset drops any frame in progress straight back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (frame_words != 8'd0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = (words_left_q == 8'd1) ? DONE : LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state; bit_out is forced low when idle
  always_comb begin
    in_ready    = (state_q == LOAD);
    bit_valid   = (state_q == SHIFT);
    bit_out     = (state_q == SHIFT) & shift_q[W-1];
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    match_count = count_q;
  end

  // Matcher: compare the low len bits of {history, current bit} against the pattern
  always_comb begin
    cand     = {hist_q, bit_out};
    seen_inc = {1'b0, seen_q} + (LW + 1)'(1);
    len_mask = '0;
    for (int i = 0; i < PW; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    last_bit = (bit_idx_q == '0);
    match    = bit_valid
             && (len_q != '0)
             && (seen_inc >= {1'b0, len_q})
             && (((cand ^ pat_q) & len_mask) == '0);
  end

  // Datapath next values: config capture, word loading, shifting, history and counting
  always_comb begin
    pat_d        = pat_q;
    len_d        = len_q;
    ovl_d        = ovl_q;
    words_left_d = words_left_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    hist_d       = hist_q;
    seen_d       = seen_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        // Config written alongside start is already in effect for that frame
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
          ovl_d = cfg_overlap;
        end
        if (start) begin
          count_d = '0;
          if (frame_words != 8'd0) begin
            words_left_d = frame_words;
            hist_d       = '0;
            seen_d       = '0;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          shift_d   = in_data;
          bit_idx_d = BW'(W - 1);
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[W-2:0], 1'b0};
        bit_idx_d = bit_idx_q - BW'(1);
        if (last_bit) begin
          words_left_d = words_left_q - 8'd1;
        end
      end
      default: begin
      end
    endcase

    // History carries across word boundaries; only a new frame clears it
    if (bit_valid) begin
      hist_d = cand[PW-2:0];
      seen_d = (seen_q >= LEN_MAX) ? seen_q : seen_inc[LW-1:0];
      if (match && !ovl_q) begin
        seen_d = '0;
      end
    end

    // Count lands the cycle after the match and sticks at all-ones
    if (match && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  // Datapath registers with reset-time default configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q        <= PAT_RST;
      len_q        <= LEN_RST;
      ovl_q        <= 1'b1;
      words_left_q <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      hist_q       <= '0;
      seen_q       <= '0;
      count_q      <= '0;
    end else begin
      pat_q        <= pat_d;
      len_q        <= len_d;
      ovl_q        <= ovl_d;
      words_left_q <= words_left_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      hist_q       <= hist_d;
      seen_q       <= seen_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed bench for seq_det_ctrl with hand-computed expectations.
// A second instance with CW=2 shares all inputs and is used for count saturation.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       start;
  logic [7:0] frame_words;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready, bit_out, bit_valid, match, busy, done;
  logic [7:0] match_count;

  logic       sat_in_ready, sat_bit_out, sat_bit_valid, sat_match, sat_busy, sat_done;
  logic [1:0] sat_match_count;

  int testsRun    = 0;
  int testsFailed = 0;

  // Per-frame observations
  logic [31:0] obsBits, obsMatches;
  int          obsNBits, obsGap;
  logic        obsDoneOnTime, obsReadyFirst;
  logic [7:0]  obsCount;
  logic [1:0]  obsSat;

  // Free-running clock
  always #5 clk = ~clk;

  seq_det_ctrl #(.W(8), .PW(8), .CW(8)) u_dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .start(start), .frame_words(frame_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
    .match_count(match_count), .busy(busy), .done(done)
  );

  seq_det_ctrl #(.W(8), .PW(8), .CW(2)) u_sat (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .start(start), .frame_words(frame_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(sat_in_ready),
    .bit_out(sat_bit_out), .bit_valid(sat_bit_valid), .match(sat_match),
    .match_count(sat_match_count), .busy(sat_busy), .done(sat_done)
  );

  // Hard stop in case something wedges the directed sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyConfig(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_we      = 1'b1;
    step();
    cfg_we      = 1'b0;
  endtask

  // Runs one frame from IDLE and records the serial stream, match positions and timing
  task automatic applyStimulus(input int nWords, input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input int gap, input logic cfgDuringFrame);
    logic [7:0] words [3];
    int   idx, gapLeft, lastBit;
    logic seenDone;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    obsBits = '0; obsMatches = '0; obsNBits = 0; obsGap = 0;
    obsDoneOnTime = 1'b0; obsReadyFirst = 1'b0; obsCount = '0; obsSat = '0;
    idx = 0; gapLeft = 0; lastBit = -1; seenDone = 1'b0;
    start       = 1'b1;
    frame_words = 8'(nWords);
    step();
    start  = 1'b0;
    cfg_we = cfgDuringFrame;
    for (int cyc = 0; cyc < 200 && !seenDone; cyc++) begin
      in_valid = (gapLeft == 0) && (idx < nWords);
      in_data  = (idx < nWords) ? words[idx] : 8'h00;
      #1;
      if (cyc == 0) obsReadyFirst = in_ready;
      if (bit_valid) begin
        obsBits = {obsBits[30:0], bit_out};
        obsMatches[obsNBits] = match;
        obsNBits++;
        lastBit = cyc;
      end
      if (gapLeft > 0 && idx < nWords && in_ready && !bit_valid) begin
        obsGap++;
        gapLeft--;
      end
      if (in_ready && in_valid) begin
        idx++;
        gapLeft = gap;
      end
      if (done) begin
        seenDone      = 1'b1;
        obsDoneOnTime = (cyc == lastBit + 1);
        obsCount      = match_count;
        obsSat        = sat_match_count;
      end
      step();
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    checkOutput("frame_done_seen", 32'(seenDone), 32'd1);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; frame_words = '0; in_valid = 1'b0; in_data = '0;
    step();
    step();
    checkOutput("reset_busy",      32'(busy),        32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),    32'd0);
    checkOutput("reset_bit_valid", 32'(bit_valid),   32'd0);
    checkOutput("reset_done",      32'(done),        32'd0);
    checkOutput("reset_count",     32'(match_count), 32'd0);
    rst = 1'b1;
    step();

    // Default config ...1010, overlapping, one word AA
    applyStimulus(1, 8'hAA, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t1_ready_first", 32'(obsReadyFirst), 32'd1);
    checkOutput("t1_bits",        obsBits,            32'hAA);
    checkOutput("t1_nbits",       32'(obsNBits),      32'd8);
    checkOutput("t1_matches",     obsMatches,         32'hA8);
    checkOutput("t1_done_time",   32'(obsDoneOnTime), 32'd1);
    checkOutput("t1_count",       32'(obsCount),      32'd3);
    step();
    step();
    checkOutput("t1_count_hold",  32'(match_count),   32'd3);
    checkOutput("t1_idle_busy",   32'(busy),          32'd0);

    // Non-overlapping mode
    applyConfig(8'h0A, 4'd4, 1'b0);
    applyStimulus(1, 8'hAA, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t2_matches", obsMatches, 32'h88);
    checkOutput("t2_count",   32'(obsCount), 32'd2);

    // Match spanning a word boundary with a 3-cycle valid gap
    applyConfig(8'h0A, 4'd4, 1'b1);
    applyStimulus(2, 8'h05, 8'h00, 8'h00, 3, 1'b0);
    checkOutput("t3_bits",      obsBits,            32'h0500);
    checkOutput("t3_nbits",     32'(obsNBits),      32'd16);
    checkOutput("t3_gap",       32'(obsGap),        32'd3);
    checkOutput("t3_matches",   obsMatches,         32'h100);
    checkOutput("t3_count",     32'(obsCount),      32'd1);
    checkOutput("t3_done_time", 32'(obsDoneOnTime), 32'd1);

    // Length 3, pattern 111, overlapping then non-overlapping
    applyConfig(8'h07, 4'd3, 1'b1);
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t4_ovl_matches", obsMatches, 32'hFC);
    checkOutput("t4_ovl_count",   32'(obsCount), 32'd6);
    applyConfig(8'h07, 4'd3, 1'b0);
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t4_novl_matches", obsMatches, 32'h24);
    checkOutput("t4_novl_count",   32'(obsCount), 32'd2);

    // Config writes during a frame are ignored, now and afterwards
    cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1;
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 0, 1'b1);
    checkOutput("t5_busy_cfg_count", 32'(obsCount), 32'd2);
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t5_after_count",    32'(obsCount), 32'd2);

    // Length above PW clamps to PW
    applyConfig(8'hAA, 4'd15, 1'b1);
    applyStimulus(1, 8'hAA, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t6_clamp_matches", obsMatches, 32'h80);
    checkOutput("t6_clamp_count",   32'(obsCount), 32'd1);

    // Length zero never matches
    applyConfig(8'hFF, 4'd0, 1'b1);
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t7_len0_matches", obsMatches, 32'h0);
    checkOutput("t7_len0_count",   32'(obsCount), 32'd0);

    // Config written together with start applies to that frame; CW=2 saturates
    cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_we = 1'b1;
    applyStimulus(3, 8'hAA, 8'hAA, 8'hAA, 0, 1'b0);
    checkOutput("t8_matches",   obsMatches,    32'hAAAAA8);
    checkOutput("t8_count",     32'(obsCount), 32'd11);
    checkOutput("t8_sat_count", 32'(obsSat),   32'd3);

    // Zero-word frame: done next cycle and count cleared
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t9_nbits",     32'(obsNBits),      32'd0);
    checkOutput("t9_done_time", 32'(obsDoneOnTime), 32'd1);
    checkOutput("t9_count",     32'(obsCount),      32'd0);

    // Asynchronous reset in the middle of SHIFT
    applyConfig(8'h07, 4'd3, 1'b0);
    start = 1'b1; frame_words = 8'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    checkOutput("t10_pre_busy",  32'(busy),        32'd1);
    checkOutput("t10_pre_count", 32'(match_count), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t10_busy",      32'(busy),        32'd0);
    checkOutput("t10_bit_valid", 32'(bit_valid),   32'd0);
    checkOutput("t10_match",     32'(match),       32'd0);
    checkOutput("t10_done",      32'(done),        32'd0);
    checkOutput("t10_count",     32'(match_count), 32'd0);
    checkOutput("t10_bit_out",   32'(bit_out),     32'd0);
    rst = 1'b1;
    step();
    applyStimulus(1, 8'hAA, 8'h00, 8'h00, 0, 1'b0);
    checkOutput("t10_default_matches", obsMatches,    32'hA8);
    checkOutput("t10_default_count",   32'(obsCount), 32'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Frame-level controller for the team's serial pattern detectors. It accepts parallel words over a valid/ready handshake and serialises them MSB-first onto a bit stream. It runs a programmable pattern matcher (pattern, length, overlap mode) on that stream, counts matches per frame, and signals busy/done, so one software-configurable block replaces the fixed-sequence FSMs.

Parameters:
W, 8, input word width in bits
PW, 8, maximum pattern length in bits
CW, 8, match counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low (0 = reset)
cfg_we  input  1  configuration write strobe, honoured only in IDLE
cfg_pattern  input  PW  pattern; bit 0 = most recent bit
cfg_len  input  $clog2(PW+1)  pattern length in bits
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
start  input  1  begin frame, honoured only in IDLE
frame_words  input  8  words in frame, sampled with start
in_valid  input  1  word available
in_data  input  W  word to serialise
in_ready  output  1  controller accepts word this cycle
bit_out  output  1  serial bit
bit_valid  output  1  bit_out is valid this cycle
match  output  1  pattern completed on the current bit
match_count  output  CW  matches in current/last frame
busy  output  1  frame in progress
done  output  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, match_count=0. Bit history and counters cleared. Config reverts to pattern=...1010 (low 4 bits 4'b1010, rest 0), len=4, overlap=1.
- States: IDLE, LOAD, SHIFT, DONE. busy = (state != IDLE).
- IDLE: in_ready=0. cfg_we latches cfg_* registers. start with frame_words!=0 -> LOAD; latch words_left=frame_words; clear match_count, history, seen-count. start with frame_words==0 -> DONE; clear match_count.
- Configuration: cfg_we outside IDLE is ignored. cfg_len>PW is clamped to PW. cfg_len==0 never matches.
- LOAD: in_ready=1. When in_valid&in_ready, capture in_data and go to SHIFT with bit index W-1. While in_valid=0, stay in LOAD with no bit_valid.
- SHIFT: one bit per cycle, MSB first; bit_valid=1. The word accepted in cycle A emits bits in cycles A+1..A+W. in_ready=0.
  - After the last bit, decrement words_left. If the result is nonzero, go to LOAD; otherwise go to DONE.
- Matcher:
  - cand = {history, bit_out}. match = bit_valid & (seen+1 >= len) & (cand[len-1:0] == pattern[len-1:0]), combinational in the same cycle as the completing bit.
  - Each bit_valid cycle: history <= cand, seen <= sat(seen+1).
  - On match with overlap=0: seen <= 0, so following bits cannot reuse matched bits.
  - History persists across word boundaries within a frame and is cleared only at start.
- match_count increments the cycle after match and saturates at 2^CW-1. It holds after done until the next accepted start.
- DONE: done=1 for exactly one cycle, then IDLE. The done pulse comes the cycle after the last bit_valid. match_count is final during the done cycle.
- start while busy is ignored; start and cfg_we together in IDLE: config latches and the frame starts, and the frame uses the new config.
- Reset mid-frame: returns to IDLE immediately. Any partial word is discarded; there is no done pulse.

Test Plan:
- Default config, frame_words=1, in_data=8'hAA held valid -> in_ready one cycle after start; bit_out 1,0,1,0,1,0,1,0; match on bits 4,6,8; done one cycle after bit 8; match_count=3.
- cfg_overlap=0, same frame as above -> match on bits 4 and 8 only; match_count=2.
- Cross-word match: frame_words=2, words 8'h05 then 8'h00, in_valid low 3 cycles between words -> in_ready high and bit_valid low during the gap; single match on first bit of word 2; match_count=1.
- Config and zero-length frame:
  - cfg_len=3, pattern=3'b111, word 8'hFF -> overlap=1 gives 6 matches; overlap=0 gives 2.
  - cfg_we pulsed while busy -> config unchanged.
  - start with frame_words=0 -> done next cycle; match_count=0.
- Saturation: CW=2, 3 words 8'hAA, overlap=1 -> match_count stops at 3.
- Async reset: rst=0 mid-SHIFT -> busy, bit_valid, match, done and match_count go to 0 without a clock edge; config returns to 1010/len 4/overlap.
